// File: rtl/rv_pkg.sv
// Shared types and constants for the rv core's Wishbone arbitration logic.
package rv_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    GNT0 = 2'd1,
    GNT1 = 2'd2
  } rv_arb_state_t;

  localparam logic ARB_M_DATA  = 1'b0;
  localparam logic ARB_M_INSTR = 1'b1;

  localparam int WB_TIMEOUT_W = 16;

endpackage

// File: rtl/rv_wb_timeout.sv
// Bus-timeout watchdog: counts cycles a granted strobe waits for ack/err and
// pulses o_expire when the wait reaches TIMEOUT_CYCLES.
module rv_wb_timeout
  import rv_pkg::*;
#(
  parameter int TIMEOUT_CYCLES = 255
) (
  input  logic i_clk,
  input  logic i_reset_n,
  input  logic i_active,
  input  logic i_stb,
  input  logic i_ack,
  input  logic i_err,
  output logic o_expire
);

  localparam logic [WB_TIMEOUT_W-1:0] LIMIT = WB_TIMEOUT_W'(TIMEOUT_CYCLES);

  logic [WB_TIMEOUT_W-1:0] count;
  logic                    stalled;

  assign stalled  = i_active & i_stb & ~i_ack & ~i_err;
  assign o_expire = stalled & (count == LIMIT);

  // Any cycle that is not a stalled strobe restarts the wait from zero.
  always_ff @(posedge i_clk or negedge i_reset_n) begin
    if (!i_reset_n) begin
      count <= '0;
    end else if (!stalled || o_expire) begin
      count <= '0;
    end else begin
      count <= count + 1'b1;
    end
  end

endmodule

// File: rtl/rv_wb_arbiter.sv
// Two-master Wishbone classic arbiter: round-robin grant held for a whole cyc,
// with response routing and a bus-timeout error for hung transfers.
module rv_wb_arbiter
  import rv_pkg::*;
#(
  parameter int TIMEOUT_CYCLES = 255
) (
  input  logic        i_clk,
  input  logic        i_reset_n,
  input  logic [31:0] i_m0_adr,
  input  logic [31:0] i_m0_dat,
  input  logic        i_m0_we,
  input  logic [3:0]  i_m0_sel,
  input  logic        i_m0_stb,
  input  logic        i_m0_cyc,
  output logic [31:0] o_m0_dat,
  output logic        o_m0_ack,
  output logic        o_m0_err,
  input  logic [31:0] i_m1_adr,
  input  logic [31:0] i_m1_dat,
  input  logic        i_m1_we,
  input  logic [3:0]  i_m1_sel,
  input  logic        i_m1_stb,
  input  logic        i_m1_cyc,
  output logic [31:0] o_m1_dat,
  output logic        o_m1_ack,
  output logic        o_m1_err,
  output logic [31:0] o_wb_adr,
  output logic [31:0] o_wb_dat,
  output logic        o_wb_we,
  output logic [3:0]  o_wb_sel,
  output logic        o_wb_stb,
  output logic        o_wb_cyc,
  input  logic [31:0] i_wb_dat,
  input  logic        i_wb_ack,
  input  logic        i_wb_err,
  output logic        o_timeout
);

  rv_arb_state_t state, state_nxt;
  logic          last_grant, last_grant_nxt;
  logic          gnt0, gnt1, granted;
  logic          sel_stb;
  logic          timeout;

  assign gnt0    = (state == GNT0);
  assign gnt1    = (state == GNT1);
  assign granted = gnt0 | gnt1;
  assign sel_stb = (gnt0 & i_m0_stb) | (gnt1 & i_m1_stb);

  rv_wb_timeout #(
    .TIMEOUT_CYCLES(TIMEOUT_CYCLES)
  ) u_timeout (
    .i_clk    (i_clk),
    .i_reset_n(i_reset_n),
    .i_active (granted),
    .i_stb    (sel_stb),
    .i_ack    (i_wb_ack),
    .i_err    (i_wb_err),
    .o_expire (timeout)
  );

  // Contention favours whichever master was not granted last; every release
  // goes through IDLE so handovers always cost one idle cycle.
  always_comb begin
    state_nxt      = state;
    last_grant_nxt = last_grant;
    unique case (state)
      IDLE: begin
        if (i_m0_cyc && (!i_m1_cyc || last_grant == ARB_M_INSTR)) begin
          state_nxt      = GNT0;
          last_grant_nxt = ARB_M_DATA;
        end else if (i_m1_cyc) begin
          state_nxt      = GNT1;
          last_grant_nxt = ARB_M_INSTR;
        end
      end
      GNT0: if (!i_m0_cyc || timeout) state_nxt = IDLE;
      GNT1: if (!i_m1_cyc || timeout) state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge i_clk or negedge i_reset_n) begin
    if (!i_reset_n) begin
      state      <= IDLE;
      last_grant <= ARB_M_INSTR;
    end else begin
      state      <= state_nxt;
      last_grant <= last_grant_nxt;
    end
  end

  // A firing timeout withdraws cyc/stb in the same cycle it reports the error.
  always_comb begin
    o_wb_adr = '0;
    o_wb_dat = '0;
    o_wb_we  = 1'b0;
    o_wb_sel = '0;
    o_wb_stb = 1'b0;
    o_wb_cyc = 1'b0;
    o_m0_dat = '0;
    o_m0_ack = 1'b0;
    o_m0_err = 1'b0;
    o_m1_dat = '0;
    o_m1_ack = 1'b0;
    o_m1_err = 1'b0;
    if (gnt0) begin
      o_wb_adr = i_m0_adr;
      o_wb_dat = i_m0_dat;
      o_wb_we  = i_m0_we;
      o_wb_sel = i_m0_sel;
      o_wb_stb = i_m0_stb & ~timeout;
      o_wb_cyc = i_m0_cyc & ~timeout;
      o_m0_dat = i_wb_dat;
      o_m0_ack = i_wb_ack;
      o_m0_err = i_wb_err | timeout;
    end else if (gnt1) begin
      o_wb_adr = i_m1_adr;
      o_wb_dat = i_m1_dat;
      o_wb_we  = i_m1_we;
      o_wb_sel = i_m1_sel;
      o_wb_stb = i_m1_stb & ~timeout;
      o_wb_cyc = i_m1_cyc & ~timeout;
      o_m1_dat = i_wb_dat;
      o_m1_ack = i_wb_ack;
      o_m1_err = i_wb_err | timeout;
    end
  end

  assign o_timeout = timeout;

endmodule

// File: tb/tb_rv_wb_arbiter.sv
// Self-checking bench for rv_wb_arbiter: directed scenarios with literal
// expectations, then randomized traffic compared every cycle to a bus-level model.
module tb_rv_wb_arbiter;

  localparam int TMO = 8;

  logic        i_clk = 1'b0;
  logic        i_reset_n = 1'b0;
  logic [31:0] m_adr[2];
  logic [31:0] m_dat[2];
  logic        m_we[2];
  logic [3:0]  m_sel[2];
  logic        m_stb[2];
  logic        m_cyc[2];
  logic [31:0] wb_dat_in;
  logic        wb_ack, wb_err;

  logic [31:0] o_m0_dat, o_m1_dat, o_wb_adr, o_wb_dat;
  logic        o_m0_ack, o_m0_err, o_m1_ack, o_m1_err;
  logic        o_wb_we, o_wb_stb, o_wb_cyc, o_timeout;
  logic [3:0]  o_wb_sel;

  int vectors = 0;
  int miscompares = 0;

  // Model state: which master owns the bus (-1 none), who was granted last,
  // and how many cycles the current strobe has waited unanswered.
  int owner = -1;
  int last  = 1;
  int stall = 0;

  rv_wb_arbiter #(.TIMEOUT_CYCLES(TMO)) dut (
    .i_clk    (i_clk),
    .i_reset_n(i_reset_n),
    .i_m0_adr (m_adr[0]),
    .i_m0_dat (m_dat[0]),
    .i_m0_we  (m_we[0]),
    .i_m0_sel (m_sel[0]),
    .i_m0_stb (m_stb[0]),
    .i_m0_cyc (m_cyc[0]),
    .o_m0_dat (o_m0_dat),
    .o_m0_ack (o_m0_ack),
    .o_m0_err (o_m0_err),
    .i_m1_adr (m_adr[1]),
    .i_m1_dat (m_dat[1]),
    .i_m1_we  (m_we[1]),
    .i_m1_sel (m_sel[1]),
    .i_m1_stb (m_stb[1]),
    .i_m1_cyc (m_cyc[1]),
    .o_m1_dat (o_m1_dat),
    .o_m1_ack (o_m1_ack),
    .o_m1_err (o_m1_err),
    .o_wb_adr (o_wb_adr),
    .o_wb_dat (o_wb_dat),
    .o_wb_we  (o_wb_we),
    .o_wb_sel (o_wb_sel),
    .o_wb_stb (o_wb_stb),
    .o_wb_cyc (o_wb_cyc),
    .i_wb_dat (wb_dat_in),
    .i_wb_ack (wb_ack),
    .i_wb_err (wb_err),
    .o_timeout(o_timeout)
  );

  always #5 i_clk = ~i_clk;

  task automatic checkOutput(input string name, input logic [31:0] act, input logic [31:0] exp);
    vectors++;
    if (act !== exp) begin
      miscompares++;
      $display("[TB] FAIL %s at %0t: got %h, expected %h", name, $time, act, exp);
    end
  endtask

  function automatic bit model_tmo();
    if (owner < 0) return 1'b0;
    return m_stb[owner] && !wb_ack && !wb_err && (stall == TMO);
  endfunction

  function automatic void model_step(output int no, output int nl, output int ns);
    bit t;
    t  = model_tmo();
    no = owner;
    nl = last;
    ns = stall;
    if (owner < 0) begin
      ns = 0;
      if (m_cyc[0] && m_cyc[1]) no = (last == 0) ? 1 : 0;
      else if (m_cyc[0])        no = 0;
      else if (m_cyc[1])        no = 1;
      if (no >= 0) nl = no;
    end else if (!m_cyc[owner] || t) begin
      no = -1;
      ns = 0;
    end else if (wb_ack || wb_err || !m_stb[owner]) begin
      ns = 0;
    end else begin
      ns = stall + 1;
    end
  endfunction

  // Advance the model at every clock edge; reset is asynchronous like the bus.
  always @(posedge i_clk or negedge i_reset_n) begin : model_update
    int a, b, c;
    if (!i_reset_n) begin
      owner <= -1;
      last  <= 1;
      stall <= 0;
    end else begin
      model_step(a, b, c);
      owner <= a;
      last  <= b;
      stall <= c;
    end
  end

  // Compare every DUT output against the model midway through each cycle.
  always @(negedge i_clk) begin : compare
    logic [31:0] e_adr, e_dat, e_d0, e_d1;
    logic [3:0]  e_sel;
    logic        e_we, e_stb, e_cyc, e_a0, e_e0, e_a1, e_e1, t;
    t = model_tmo();
    e_adr = '0; e_dat = '0; e_d0 = '0; e_d1 = '0; e_sel = '0;
    e_we = 0; e_stb = 0; e_cyc = 0; e_a0 = 0; e_e0 = 0; e_a1 = 0; e_e1 = 0;
    if (owner >= 0) begin
      e_adr = m_adr[owner];
      e_dat = m_dat[owner];
      e_we  = m_we[owner];
      e_sel = m_sel[owner];
      e_stb = m_stb[owner] & ~t;
      e_cyc = m_cyc[owner] & ~t;
      if (owner == 0) begin
        e_d0 = wb_dat_in; e_a0 = wb_ack; e_e0 = wb_err | t;
      end else begin
        e_d1 = wb_dat_in; e_a1 = wb_ack; e_e1 = wb_err | t;
      end
    end
    checkOutput("wb_adr", o_wb_adr, e_adr);
    checkOutput("wb_dat", o_wb_dat, e_dat);
    checkOutput("wb_we", o_wb_we, e_we);
    checkOutput("wb_sel", o_wb_sel, e_sel);
    checkOutput("wb_stb", o_wb_stb, e_stb);
    checkOutput("wb_cyc", o_wb_cyc, e_cyc);
    checkOutput("m0_dat", o_m0_dat, e_d0);
    checkOutput("m0_ack", o_m0_ack, e_a0);
    checkOutput("m0_err", o_m0_err, e_e0);
    checkOutput("m1_dat", o_m1_dat, e_d1);
    checkOutput("m1_ack", o_m1_ack, e_a1);
    checkOutput("m1_err", o_m1_err, e_e1);
    checkOutput("timeout", o_timeout, t);
  end

  task automatic tick();
    @(posedge i_clk);
    #1;
  endtask

  task automatic mid();
    #4;
  endtask

  task automatic idleAll();
    for (int i = 0; i < 2; i++) begin
      m_adr[i] = '0; m_dat[i] = '0; m_we[i] = 1'b0; m_sel[i] = '0;
      m_stb[i] = 1'b0; m_cyc[i] = 1'b0;
    end
    wb_dat_in = '0; wb_ack = 1'b0; wb_err = 1'b0;
  endtask

  task automatic request(input int m, input logic [31:0] adr);
    m_cyc[m] = 1'b1; m_stb[m] = 1'b1; m_adr[m] = adr;
    m_dat[m] = adr ^ 32'h5A5A_5A5A; m_sel[m] = 4'hF; m_we[m] = 1'b0;
  endtask

  task automatic release_m(input int m);
    m_cyc[m] = 1'b0; m_stb[m] = 1'b0;
  endtask

  // Both masters raise cyc together; each completes one acked transfer.
  task automatic contend(input int first);
    int second;
    logic [31:0] a_first, a_second;
    second   = 1 - first;
    a_first  = (first == 0) ? 32'h2000_0000 : 32'h3000_0000;
    a_second = (first == 0) ? 32'h3000_0000 : 32'h2000_0000;
    tick();
    request(0, 32'h2000_0000);
    request(1, 32'h3000_0000);
    mid(); checkOutput("cont_c0_cyc", o_wb_cyc, 1'b0);
    tick();
    wb_ack = 1'b1; wb_dat_in = 32'h1111_0000;
    mid();
    checkOutput("cont_first_adr", o_wb_adr, a_first);
    checkOutput("cont_first_ack0", o_m0_ack, (first == 0));
    checkOutput("cont_first_ack1", o_m1_ack, (first == 1));
    tick();
    wb_ack = 1'b0; release_m(first);
    mid(); checkOutput("cont_release_cyc", o_wb_cyc, 1'b0);
    tick();
    mid(); checkOutput("cont_idle_cyc", o_wb_cyc, 1'b0);
    tick();
    wb_ack = 1'b1;
    mid();
    checkOutput("cont_second_cyc", o_wb_cyc, 1'b1);
    checkOutput("cont_second_adr", o_wb_adr, a_second);
    checkOutput("cont_second_ack0", o_m0_ack, (second == 0));
    checkOutput("cont_second_ack1", o_m1_ack, (second == 1));
    tick();
    wb_ack = 1'b0; release_m(second);
    mid(); checkOutput("cont_end_cyc", o_wb_cyc, 1'b0);
    tick();
  endtask

  task automatic applyStimulus(input int ack_pct, input bit hang);
    for (int i = 0; i < 2; i++) begin
      if ($urandom_range(0, 7) == 0) m_cyc[i] = ~m_cyc[i];
      if (m_cyc[i]) m_stb[i] = hang ? 1'b1 : ($urandom_range(0, 7) != 0);
      else          m_stb[i] = ($urandom_range(0, 15) == 0);
      m_adr[i] = $urandom;
      m_dat[i] = $urandom;
      m_we[i]  = 1'($urandom_range(0, 1));
      m_sel[i] = 4'($urandom_range(0, 15));
    end
    wb_dat_in = $urandom;
    wb_ack    = ($urandom_range(0, 99) < ack_pct);
    wb_err    = hang ? 1'b0 : ($urandom_range(0, 19) == 0);
  endtask

  initial begin
    idleAll();
    #1;
    checkOutput("reset_wb_cyc", o_wb_cyc, 1'b0);
    checkOutput("reset_wb_adr", o_wb_adr, 32'h0);
    checkOutput("reset_timeout", o_timeout, 1'b0);
    #11;
    i_reset_n = 1'b1;

    // Contention straight after reset: master 0 first.
    contend(0);

    // Single read by master 0 with a slave answering in cycle 3.
    tick();
    request(0, 32'h1000_0004);
    mid(); checkOutput("rd_c0_cyc", o_wb_cyc, 1'b0);
    tick();
    mid();
    checkOutput("rd_c1_cyc", o_wb_cyc, 1'b1);
    checkOutput("rd_c1_adr", o_wb_adr, 32'h1000_0004);
    tick();
    mid();
    checkOutput("rd_c2_cyc", o_wb_cyc, 1'b1);
    checkOutput("rd_c2_ack", o_m0_ack, 1'b0);
    tick();
    wb_ack = 1'b1; wb_dat_in = 32'hDEAD_BEEF;
    mid();
    checkOutput("rd_c3_cyc", o_wb_cyc, 1'b1);
    checkOutput("rd_c3_ack", o_m0_ack, 1'b1);
    checkOutput("rd_c3_dat", o_m0_dat, 32'hDEAD_BEEF);
    tick();
    wb_ack = 1'b0; wb_dat_in = '0; release_m(0);
    mid(); checkOutput("rd_c4_cyc", o_wb_cyc, 1'b0);
    tick();
    wb_ack = 1'b1;
    mid();
    checkOutput("stray_ack_m0", o_m0_ack, 1'b0);
    checkOutput("stray_ack_m1", o_m1_ack, 1'b0);
    tick();
    wb_ack = 1'b0;
    mid(); checkOutput("stray_no_grant", o_wb_cyc, 1'b0);

    // Last grant went to master 0, so this contention favours master 1.
    contend(1);

    // Timeout: slave never answers.
    tick();
    request(0, 32'h0BAD_0000);
    tick();
    for (int c = 1; c <= TMO; c++) begin
      mid();
      checkOutput("tmo_wait_cyc", o_wb_cyc, 1'b1);
      checkOutput("tmo_wait_pulse", o_timeout, 1'b0);
      tick();
    end
    mid();
    checkOutput("tmo_err", o_m0_err, 1'b1);
    checkOutput("tmo_pulse", o_timeout, 1'b1);
    checkOutput("tmo_cyc_drop", o_wb_cyc, 1'b0);
    checkOutput("tmo_stb_drop", o_wb_stb, 1'b0);
    tick();
    release_m(0);
    mid();
    checkOutput("tmo_after_cyc", o_wb_cyc, 1'b0);
    checkOutput("tmo_after_err", o_m0_err, 1'b0);
    checkOutput("tmo_after_pulse", o_timeout, 1'b0);
    tick();

    // Burst hold: master 1 keeps cyc over four acked strobes.
    tick();
    request(1, 32'h4000_0000);
    tick();
    request(0, 32'h5000_0000);
    wb_ack = 1'b1;
    for (int c = 0; c < 4; c++) begin
      mid();
      checkOutput("burst_adr", o_wb_adr, 32'h4000_0000);
      checkOutput("burst_ack1", o_m1_ack, 1'b1);
      checkOutput("burst_ack0", o_m0_ack, 1'b0);
      tick();
    end
    wb_ack = 1'b0; release_m(1);
    mid(); checkOutput("burst_rel_cyc", o_wb_cyc, 1'b0);
    tick();
    mid(); checkOutput("burst_idle_cyc", o_wb_cyc, 1'b0);
    tick();
    wb_ack = 1'b1;
    mid();
    checkOutput("burst_m0_cyc", o_wb_cyc, 1'b1);
    checkOutput("burst_m0_adr", o_wb_adr, 32'h5000_0000);
    checkOutput("burst_m0_ack", o_m0_ack, 1'b1);
    tick();
    wb_ack = 1'b0; release_m(0);
    tick();
    wb_ack = 1'b1; wb_err = 1'b1;
    mid();
    checkOutput("stray2_ack0", o_m0_ack, 1'b0);
    checkOutput("stray2_err0", o_m0_err, 1'b0);
    checkOutput("stray2_err1", o_m1_err, 1'b0);
    tick();
    wb_ack = 1'b0; wb_err = 1'b0;

    // Asynchronous reset in the middle of a granted transfer.
    tick();
    request(1, 32'h6000_0000);
    tick();
    mid(); checkOutput("rst_pre_cyc", o_wb_cyc, 1'b1);
    #2;
    i_reset_n = 1'b0;
    #1;
    checkOutput("rst_async_cyc", o_wb_cyc, 1'b0);
    checkOutput("rst_async_stb", o_wb_stb, 1'b0);
    checkOutput("rst_async_adr", o_wb_adr, 32'h0);
    release_m(1);
    @(posedge i_clk);
    #3;
    i_reset_n = 1'b1;
    contend(0);

    // Randomized traffic: normal, then a hung slave, then busy acks.
    for (int c = 0; c < 3000; c++) begin
      tick();
      if (c < 1000)      applyStimulus(30, 1'b0);
      else if (c < 1600) applyStimulus(0, 1'b1);
      else               applyStimulus(60, 1'b0);
    end
    tick();
    idleAll();
    tick();
    tick();
    mid();

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule

// File: doc/rv_wb_arbiter.md
# rv_wb_arbiter

Two-master Wishbone classic arbiter that shares the core's single external Wishbone bus between the data-memory port (master 0) and a fetch-side port for off-TCM instructions (master 1). It sits between `rv_core` and the system interconnect. It arbitrates round-robin, holds the grant for the whole `cyc` cycle, routes data, ack and err back to the granting master, and ends hung transfers with a bus-timeout error.

## Interface
Parameters:
- `TIMEOUT_CYCLES`, default 255: cycles `stb` may stay unacknowledged before a timeout error; legal range is 1 to 65535.

Ports:
- `i_clk` in 1: the only clock; all state changes on the rising edge.
- `i_reset_n` in 1: reset; asynchronous assert, active-low.
- `i_m0_adr` / `i_m0_dat` in 32 each: master 0 (data) address and write data.
- `i_m0_we` in 1, `i_m0_sel` in 4: master 0 write enable and byte selects.
- `i_m0_stb` / `i_m0_cyc` in 1 each: master 0 strobe and cycle.
- `o_m0_dat` out 32: read data returned to master 0.
- `o_m0_ack` / `o_m0_err` out 1 each: master 0 acknowledge and error.
- `i_m1_*` / `o_m1_*`: same set as master 0, for master 1 (instruction).
- `o_wb_adr` / `o_wb_dat` out 32 each: bus address and write data.
- `o_wb_we` out 1, `o_wb_sel` out 4: bus write enable and byte selects.
- `o_wb_stb` / `o_wb_cyc` out 1 each: bus strobe and cycle.
- `i_wb_dat` in 32: bus read data.
- `i_wb_ack` / `i_wb_err` in 1 each: bus acknowledge and error.
- `o_timeout` out 1: one-cycle pulse when a timeout fires.

## Operation
- FSM states:
  - `IDLE`: no grant. Bus `cyc` and `stb` are 0, and all master `ack`/`err` outputs are 0.
  - `GNT0` / `GNT1`: the named master owns the bus.
- `IDLE` -> `GNTx` on a rising edge when `i_mx_cyc` is 1.
- Both masters requesting in `IDLE`: grant the master not granted last. The last-grant register resets to 1, so master 0 wins the first contention.
- While in `GNTx`:
  - `o_wb_adr/dat/we/sel/stb` mirror master x combinationally; `o_wb_cyc` = `i_mx_cyc`.
  - `o_mx_dat` = `i_wb_dat`; `o_mx_ack` = `i_wb_ack`; `o_mx_err` = `i_wb_err` or the timeout pulse.
  - The other master's `ack` and `err` are 0. Its `dat` output is don't-care, driven to 0.
- Leaving `GNTx`: go to `IDLE` when `i_mx_cyc` is 0 or a timeout fires. There is no direct GNT-to-GNT hop; every handover passes one `IDLE` cycle.
- Timeout counter (16-bit):
  - Clears in `IDLE`, on `i_wb_ack`, on `i_wb_err`, and whenever the granted `stb` is 0.
  - Increments each granted cycle with `stb`=1 and no ack/err.
  - When the count equals `TIMEOUT_CYCLES` with no ack/err: pulse `o_timeout` and `o_mx_err`, and force `o_wb_cyc`/`o_wb_stb` to 0 in that cycle.
- `i_wb_ack`/`i_wb_err` arriving in `IDLE` are ignored.
- Ack and err together: both are forwarded; the master gives err precedence.
- Reset, including mid-transfer: state goes to `IDLE` and last-grant to 1. The counter clears. `o_wb_cyc`, `o_wb_stb`, `o_wb_we`, `o_timeout` and every master `ack`/`err` are 0 immediately. Address, data and sel outputs are 0.

## Timing
- Grant latency: `i_mx_cyc` rising at cycle N gives `o_wb_cyc` = 1 at N+1.
- Ack path is combinational, zero cycles: `i_wb_ack` at cycle M gives `o_mx_ack` at M.
- Release: `i_mx_cyc` at 0 in cycle K gives `IDLE` at K+1; the earliest other grant is K+2.
- Timeout: with `stb` held from the grant cycle G and no ack, the err and `o_timeout` pulse appear at G+`TIMEOUT_CYCLES`, and the state is `IDLE` at G+`TIMEOUT_CYCLES`+1.
- Back-to-back transfers under one held `cyc` keep the grant with no idle gap.

## Structure
- In `rv_pkg`:
  - typedef `rv_arb_state_t` (`IDLE`, `GNT0`, `GNT1`).
  - constants `ARB_M_DATA`=0, `ARB_M_INSTR`=1.
  - width constant `WB_TIMEOUT_W`=16.
- Sub-module `rv_wb_timeout`: holds the counter, its clear/enable logic and the expire pulse. The arbiter top holds the FSM and the muxes.

## Test plan
- Single read: master 0 requests at cycle 0 with addr 0x1000_0004; slave acks at cycle 3 with 0xDEADBEEF -> `o_wb_cyc` high in cycles 1-3, `o_m0_ack` at 3 with data 0xDEADBEEF, `IDLE` at 5.
- Contention: both masters raise `cyc` at cycle 0 and each does one acked transfer -> master 0 granted at 1; master 1 granted one `IDLE` cycle after master 0 releases. Repeating the contention grants master 1 first.
- Burst hold: master 1 keeps `cyc` for 4 acked strobes while master 0 requests -> master 0 is not granted until master 1 drops `cyc`.
- Timeout with `TIMEOUT_CYCLES`=8 and a slave that never acks: master 0 granted at 1 -> `o_m0_err` and `o_timeout` at 9, `o_wb_cyc` 0 at 9, `IDLE` at 10.
- Stray ack: `i_wb_ack` pulsed in `IDLE` -> no master `ack`, no state change.
- Async reset asserted mid-transfer -> `o_wb_cyc`/`stb` drop in the same cycle with no clock edge. After release, the first contention grants master 0.
